mul_rnd_pipe: RTL and testbench

Pipelined, parametrised rounding and packing stage for the floating-point multiplier datapath. It takes the raw double-width significand product, biased exponent and sign from the multiply array. It then normalises the product, rounds in one of five IEEE-754 modes, and handles subnormal promotion, overflow saturation and signed-zero results. It emits a packed result with exception flags over a two-stage valid/ready pipeline, so it can sit between the multiplier array and the writeback/FIFO logic under backpressure.

---
 rtl/mul_rnd_pipe.sv | 219 +++++++++++++++++++++
 tb/tb_mul_rnd_pipe.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_rnd_pipe.sv
// mul_rnd_pipe: rounding and packing stage for the floating-point multiplier.
// Takes the double-width significand product, biased exponent and sign.
// Normalises the product and rounds it in one of five modes. Then resolves
// subnormal promotion, overflow saturation and signed zero. The packed result
// leaves with exception flags through a two-stage valid/ready pipeline.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake (in_ready is combinational)
//   sign_in               product sign
//   mant_in               significand product, overflow bit at 2*MANT_W+1
//   expo_in               unsigned biased exponent (0 = denormalised upstream)
//   sticky_in             OR of bits already discarded upstream
//   rnd                   rounding mode: RNE, RTZ, RDN, RUP, RMM (101-111 -> RNE)
//   a_is_n0, b_is_n0      operand non-zero indicators
//   out_valid / out_ready output handshake
//   sign_out, expo_out,   packed result fields
//   mant_out
//   flag_nx/of/uf         inexact, overflow, underflow
module mul_rnd_pipe #(
    parameter int unsigned EXPO_W = 8,
    parameter int unsigned MANT_W = 23
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                sign_in,
    input  logic [2*MANT_W+1:0] mant_in,
    input  logic [EXPO_W+1:0]   expo_in,
    input  logic                sticky_in,
    input  logic [2:0]          rnd,
    input  logic                a_is_n0,
    input  logic                b_is_n0,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                sign_out,
    output logic [EXPO_W-1:0]   expo_out,
    output logic [MANT_W-1:0]   mant_out,
    output logic                flag_nx,
    output logic                flag_of,
    output logic                flag_uf
);

    localparam int unsigned PW = 2 * MANT_W + 2;  // product width
    localparam int unsigned KW = MANT_W + 1;      // kept significand incl. hidden bit
    localparam int unsigned SW = KW + 1;          // rounding adder width
    localparam int unsigned XW = EXPO_W + 3;      // exponent headroom for +1 and carry

    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    // Rounded beat handed from S1 to S2.
    typedef struct packed {
        logic          sign;
        logic          zero;      // an operand was zero
        logic          inf_ovf;   // overflow saturates to infinity (else max finite)
        logic          inexact;   // guard or sticky was set
        logic          exp_zero;  // normalised exponent was 0 (subnormal input)
        logic [XW-1:0] expo;      // exponent after normalise and rounding carry
        logic [KW-1:0] sig;       // rounded significand incl. hidden bit
    } s1_t;

    logic  s1_valid;
    s1_t   s1_q;
    s1_t   s1_nxt;
    logic  s1_adv;
    logic  s2_adv;

    // Pipeline advance: a stage moves when it is empty or its consumer takes it.
    always_comb begin
        s2_adv = ~out_valid | out_ready;
        s1_adv = ~s1_valid | s2_adv;
    end

    assign in_ready = s1_adv;

    // ------------------------------------------------------------------
    // S1: normalise, guard/sticky extraction, rounding increment.
    // ------------------------------------------------------------------
    logic                ovf_bit;
    logic [PW-2:0]       norm;
    logic [XW-1:0]       norm_exp;
    logic [KW-1:0]       kept;
    logic                g;
    logic                s;
    logic                inc;
    logic                inf_sel;
    logic [SW-1:0]       sum;
    logic                carry;

    always_comb begin
        ovf_bit  = mant_in[PW-1];
        norm     = ovf_bit ? mant_in[PW-1:1] : mant_in[PW-2:0];
        norm_exp = XW'(expo_in) + XW'(ovf_bit);
        kept     = norm[2*MANT_W -: KW];
        g        = norm[MANT_W-1];
        // bit lost by the normalising shift joins the sticky
        s        = (|norm[MANT_W-2:0]) | sticky_in | (ovf_bit & mant_in[0]);

        inc     = g & (s | kept[0]);
        inf_sel = 1'b1;
        case (rnd)
            RM_RTZ: begin
                inc     = 1'b0;
                inf_sel = 1'b0;
            end
            RM_RDN: begin
                inc     = sign_in & (g | s);
                inf_sel = sign_in;
            end
            RM_RUP: begin
                inc     = ~sign_in & (g | s);
                inf_sel = ~sign_in;
            end
            RM_RMM: begin
                inc     = g;
                inf_sel = 1'b1;
            end
            default: begin
                inc     = g & (s | kept[0]);
                inf_sel = 1'b1;
            end
        endcase

        sum   = SW'(kept) + SW'(inc);
        carry = sum[KW];

        s1_nxt          = '0;
        s1_nxt.sign     = sign_in;
        s1_nxt.zero     = ~(a_is_n0 & b_is_n0);
        s1_nxt.inf_ovf  = inf_sel;
        s1_nxt.inexact  = g | s;
        s1_nxt.exp_zero = (norm_exp == '0);
        s1_nxt.expo     = norm_exp + XW'(carry);
        s1_nxt.sig      = carry ? sum[KW:1] : sum[KW-1:0];
    end

    // S1 register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q <= s1_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: subnormal promotion, overflow saturation, flags, zero result.
    // ------------------------------------------------------------------
    logic [XW-1:0]     exp_f;
    logic              ovf;
    logic              nx_nxt;
    logic              of_nxt;
    logic              uf_nxt;
    logic [EXPO_W-1:0] expo_nxt;
    logic [MANT_W-1:0] mant_nxt;

    always_comb begin
        // rounding into the hidden bit lifts a subnormal to the smallest normal
        exp_f    = (s1_q.exp_zero && s1_q.sig[MANT_W]) ? XW'(1) : s1_q.expo;
        ovf      = (exp_f >= XW'({EXPO_W{1'b1}}));

        expo_nxt = exp_f[EXPO_W-1:0];
        mant_nxt = s1_q.sig[MANT_W-1:0];
        nx_nxt   = s1_q.inexact;
        of_nxt   = 1'b0;
        uf_nxt   = (exp_f == '0) & s1_q.inexact;

        if (s1_q.zero) begin
            expo_nxt = '0;
            mant_nxt = '0;
            nx_nxt   = 1'b0;
            of_nxt   = 1'b0;
            uf_nxt   = 1'b0;
        end else if (ovf) begin
            nx_nxt = 1'b1;
            of_nxt = 1'b1;
            uf_nxt = 1'b0;
            if (s1_q.inf_ovf) begin
                expo_nxt = {EXPO_W{1'b1}};
                mant_nxt = '0;
            end else begin
                expo_nxt = {{(EXPO_W-1){1'b1}}, 1'b0};
                mant_nxt = {MANT_W{1'b1}};
            end
        end
    end

    // S2 register drives the outputs directly; held while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sign_out  <= 1'b0;
            expo_out  <= '0;
            mant_out  <= '0;
            flag_nx   <= 1'b0;
            flag_of   <= 1'b0;
            flag_uf   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sign_out <= s1_q.sign;
                expo_out <= expo_nxt;
                mant_out <= mant_nxt;
                flag_nx  <= nx_nxt;
                flag_of  <= of_nxt;
                flag_uf  <= uf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_mul_rnd_pipe.sv
// Testbench for mul_rnd_pipe (EXPO_W=8, MANT_W=23): directed vectors plus
// randomized beats checked against an arithmetic reference model and an
// in-order scoreboard, with backpressure and mid-flight reset.
module tb_mul_rnd_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [47:0] mant_in;
    logic [9:0]  expo_in;
    logic        sticky_in;
    logic [2:0]  rnd;
    logic        a_is_n0;
    logic        b_is_n0;
    logic        out_valid;
    logic        out_ready;
    logic        sign_out;
    logic [7:0]  expo_out;
    logic [22:0] mant_out;
    logic        flag_nx;
    logic        flag_of;
    logic        flag_uf;

    logic rand_mode = 1'b0;
    logic ready_rnd = 1'b1;
    logic ready_dir = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [34:0] exp_q[$];   // {nx, of, uf, packed word}

    localparam longint unsigned HALF = 64'd1 << 22;

    typedef struct {
        logic        sgn;
        logic [47:0] m;
        logic [9:0]  e;
        logic        stk;
        logic [2:0]  rm;
        logic        an;
        logic        bn;
    } beat_t;

    mul_rnd_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_in   (sign_in),
        .mant_in   (mant_in),
        .expo_in   (expo_in),
        .sticky_in (sticky_in),
        .rnd       (rnd),
        .a_is_n0   (a_is_n0),
        .b_is_n0   (b_is_n0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign_out  (sign_out),
        .expo_out  (expo_out),
        .mant_out  (mant_out),
        .flag_nx   (flag_nx),
        .flag_of   (flag_of),
        .flag_uf   (flag_uf)
    );

    assign out_ready = rand_mode ? ready_rnd : ready_dir;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        ready_rnd = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [34:0] obs_word();
        return {flag_nx, flag_of, flag_uf, sign_out, expo_out, mant_out};
    endfunction

    // Reference: real-valued rounding of the significand with plain integers.
    function automatic logic [34:0] model(input beat_t b);
        longint unsigned mm, kept, rem, r;
        int          e, e0;
        bit          sticky, inexact, above, tie, inc, inf;
        logic [31:0] w;
        if (!(b.an && b.bn)) return {3'b000, b.sgn, 31'd0};
        mm     = 64'(b.m);
        e      = int'(b.e);
        sticky = b.stk;
        if (mm >= (64'd1 << 47)) begin
            sticky = sticky || (mm % 2 == 1);
            mm     = mm >> 1;
            e      = e + 1;
        end
        e0      = e;
        kept    = mm >> 23;
        rem     = mm % (64'd1 << 23);
        inexact = (rem != 0) || sticky;
        above   = (rem > HALF) || (rem == HALF && sticky);
        tie     = (rem == HALF) && !sticky;
        case (b.rm)
            3'd1:    inc = 1'b0;
            3'd2:    inc = b.sgn && inexact;
            3'd3:    inc = !b.sgn && inexact;
            3'd4:    inc = (rem >= HALF);
            default: inc = above || (tie && (kept % 2 == 1));
        endcase
        r = kept + 64'(inc);
        if (r >= (64'd1 << 24)) begin
            r = r >> 1;
            e = e + 1;
        end
        if (e0 == 0 && r >= (64'd1 << 23)) e = 1;
        if (e >= 255) begin
            inf = (b.rm == 3'd0) || (b.rm >= 3'd4) || (b.rm == 3'd3 && !b.sgn) ||
                  (b.rm == 3'd2 && b.sgn);
            w = inf ? {b.sgn, 8'hFF, 23'd0} : {b.sgn, 8'hFE, 23'h7FFFFF};
            return {3'b110, w};
        end
        w = {b.sgn, 8'(e), 23'(r)};
        return {inexact, 1'b0, (e == 0) && inexact, w};
    endfunction

    function automatic beat_t mk(input logic sgn, input logic [47:0] m, input logic [9:0] e,
                                 input logic stk, input logic [2:0] rm, input logic an,
                                 input logic bn);
        beat_t b;
        b.sgn = sgn; b.m = m; b.e = e; b.stk = stk; b.rm = rm; b.an = an; b.bn = bn;
        return b;
    endfunction

    function automatic beat_t rand_beat();
        beat_t           b;
        longint unsigned pa, pb;
        if ($urandom_range(0, 1) == 0) begin
            pa  = 64'({1'b1, 23'($urandom)});
            pb  = 64'({1'b1, 23'($urandom)});
            b.m = 48'(pa * pb);
        end else begin
            b.m = {16'($urandom), 32'($urandom)};
        end
        b.e   = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023))
                                            : 10'($urandom_range(0, 260));
        b.sgn = 1'($urandom);
        b.stk = ($urandom_range(0, 3) == 0);
        b.rm  = 3'($urandom_range(0, 7));
        b.an  = ($urandom_range(0, 15) != 0);
        b.bn  = ($urandom_range(0, 15) != 0);
        return b;
    endfunction

    task automatic drive(input beat_t b);
        sign_in   = b.sgn;
        mant_in   = b.m;
        expo_in   = b.e;
        sticky_in = b.stk;
        rnd       = b.rm;
        a_is_n0   = b.an;
        b_is_n0   = b.bn;
        in_valid  = 1'b1;
    endtask

    // Offer a beat until accepted; returns 1 time unit after the capture edge.
    task automatic send(input beat_t b);
        int   waited = 0;
        logic acc    = 1'b0;
        drive(b);
        while (!acc && waited < 200) begin
            @(negedge clk);
            acc = in_ready && !rst;
            if (acc) exp_q.push_back(model(b));
            @(posedge clk);
            #1;
            waited++;
        end
        check("accept", 64'(acc), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic dir(input string tag, input beat_t b, input logic [34:0] expv);
        ready_dir = 1'b1;
        send(b);
        check({tag, "_lat1"}, 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        check({tag, "_lat2"}, 64'(out_valid), 64'(1));
        check(tag, 64'(obs_word()), 64'(expv));
    endtask

    task automatic drain();
        int n = 0;
        ready_dir = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'(0));
    endtask

    // Scoreboard: every delivered result must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            check("beat_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) check("scoreboard", 64'(obs_word()), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        logic [47:0] tie_m;
        logic [47:0] ovf_m;
        logic [47:0] sub_m;
        logic [47:0] uf_m;
        logic [34:0] snap;
        beat_t       b0, b1, b2;

        tie_m = {2'b01, 23'h000001, 1'b1, 22'h0};
        ovf_m = {2'b01, 46'h3FFF_FFFF_FFFF};
        sub_m = {2'b00, 23'h7FFFFF, 1'b1, 22'h0};
        uf_m  = {2'b00, 23'h000100, 1'b1, 22'h1};

        rst = 1'b1; in_valid = 1'b0; sign_in = 1'b0; mant_in = '0; expo_in = '0;
        sticky_in = 1'b0; rnd = 3'd0; a_is_n0 = 1'b1; b_is_n0 = 1'b1;
        #3;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_outputs", 64'(obs_word()), 64'(0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Directed vectors
        dir("mul_1p5", mk(1'b0, 48'h9000_0000_0000, 10'd127, 1'b0, 3'd0, 1'b1, 1'b1),
            {3'b000, 32'h40100000});
        dir("tie_rne", mk(1'b0, tie_m, 10'd100, 1'b0, 3'd0, 1'b1, 1'b1), {3'b100, 32'h32000002});
        dir("tie_rtz", mk(1'b0, tie_m, 10'd100, 1'b0, 3'd1, 1'b1, 1'b1), {3'b100, 32'h32000001});
        dir("tie_rmm", mk(1'b0, tie_m, 10'd100, 1'b0, 3'd4, 1'b1, 1'b1), {3'b100, 32'h32000002});
        dir("tie_rdn", mk(1'b0, tie_m, 10'd100, 1'b0, 3'd2, 1'b1, 1'b1), {3'b100, 32'h32000001});
        dir("tie_rm6", mk(1'b0, tie_m, 10'd100, 1'b0, 3'd6, 1'b1, 1'b1), {3'b100, 32'h32000002});
        dir("ovf_rne", mk(1'b0, ovf_m, 10'd254, 1'b0, 3'd0, 1'b1, 1'b1), {3'b110, 32'h7F800000});
        // truncation lands exactly on max finite at exponent 254: inexact only
        dir("ovf_rtz254", mk(1'b0, ovf_m, 10'd254, 1'b0, 3'd1, 1'b1, 1'b1), {3'b100, 32'h7F7FFFFF});
        dir("ovf_rdn_neg", mk(1'b1, ovf_m, 10'd254, 1'b0, 3'd2, 1'b1, 1'b1), {3'b110, 32'hFF800000});
        dir("ovf_rtz255", mk(1'b0, ovf_m, 10'd255, 1'b0, 3'd1, 1'b1, 1'b1), {3'b110, 32'h7F7FFFFF});
        dir("ovf_rup_neg", mk(1'b1, ovf_m, 10'd255, 1'b0, 3'd3, 1'b1, 1'b1), {3'b110, 32'hFF7FFFFF});
        dir("subnorm", mk(1'b0, sub_m, 10'd0, 1'b0, 3'd0, 1'b1, 1'b1), {3'b100, 32'h00800000});
        dir("underflow", mk(1'b0, uf_m, 10'd0, 1'b0, 3'd0, 1'b1, 1'b1), {3'b101, 32'h00000101});
        dir("shift_rne", mk(1'b0, 48'hC000_0000_0001, 10'd127, 1'b0, 3'd0, 1'b1, 1'b1),
            {3'b100, 32'h40400000});
        dir("shift_rup", mk(1'b0, 48'hC000_0000_0001, 10'd127, 1'b0, 3'd3, 1'b1, 1'b1),
            {3'b100, 32'h40400001});
        dir("zero_a", mk(1'b1, 48'h9000_0000_0000, 10'd127, 1'b1, 3'd3, 1'b0, 1'b1),
            {3'b000, 32'h80000000});
        dir("zero_b", mk(1'b1, ovf_m, 10'd255, 1'b1, 3'd7, 1'b1, 1'b0), {3'b000, 32'h80000000});
        drain();

        // Back-to-back throughput
        for (int i = 0; i < 4; i++) begin
            send(rand_beat());
            if (i > 0) check("throughput", 64'(out_valid), 64'(1));
        end
        drain();

        // Backpressure: two beats fill the pipe, the third is refused
        ready_dir = 1'b0;
        b0 = rand_beat(); b1 = rand_beat(); b2 = rand_beat();
        send(b0);
        check("bp_ready1", 64'(in_ready), 64'(1));
        send(b1);
        check("bp_full", 64'(in_ready), 64'(0));
        snap = obs_word();
        drive(b2);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_in_ready", 64'(in_ready), 64'(0));
            check("bp_out_valid", 64'(out_valid), 64'(1));
            check("bp_stable", 64'(obs_word()), 64'(snap));
        end
        ready_dir = 1'b1;
        #1;
        check("bp_release", 64'(in_ready), 64'(1));
        send(b2);
        drain();

        // Reset with two beats in flight
        ready_dir = 1'b0;
        send(rand_beat());
        send(rand_beat());
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_ready", 64'(in_ready), 64'(1));
        check("mid_rst_outputs", 64'(obs_word()), 64'(0));
        exp_q.delete();
        ready_dir = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_idle", 64'(out_valid), 64'(0));
        end

        // Randomized traffic with random backpressure
        rand_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(rand_beat());
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_mode = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
